// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the core load/store port (0)
// and a loader/debug port (1). Owner-priority arbitration with a bounded burst
// length. Grants are combinational and read data is returned one cycle later.
module dmem_arbiter #(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r0_gnt,
  output logic          r1_gnt,
  output logic          r0_rvalid,
  output logic          r1_rvalid,
  output logic [DW-1:0] r0_rdata,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_writedata,
  output logic          mem_memread,
  output logic          mem_memwrite,
  input  logic [DW-1:0] mem_readdata,
  output logic          owner
);

  localparam int unsigned   CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);

  logic          owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          r0_rvalid_q, r0_rvalid_d;
  logic          r1_rvalid_q, r1_rvalid_d;
  logic [DW-1:0] r0_rdata_q, r0_rdata_d;
  logic [DW-1:0] r1_rdata_q, r1_rdata_d;

  logic          gnt_any;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Grant decision; gated by reset so no access can slip through while rst is low
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    if (rst) begin
      if (r0_req && r1_req) begin
        if (cnt_q < CNT_MAX) begin
          r0_gnt = ~owner_q;
          r1_gnt = owner_q;
        end else begin
          r0_gnt = owner_q;
          r1_gnt = ~owner_q;
        end
      end else begin
        r0_gnt = r0_req;
        r1_gnt = r1_req;
      end
    end
  end

  // Memory drive from the winning port; everything zero when idle
  always_comb begin
    gnt_any       = r0_gnt | r1_gnt;
    sel_we        = r1_gnt ? r1_we    : r0_we;
    sel_addr      = r1_gnt ? r1_addr  : r0_addr;
    sel_wdata     = r1_gnt ? r1_wdata : r0_wdata;
    mem_address   = gnt_any ? sel_addr : '0;
    mem_memread   = gnt_any & ~sel_we;
    mem_memwrite  = gnt_any & sel_we;
    mem_writedata = (gnt_any & sel_we) ? sel_wdata : '0;
  end

  // Next-state: owner/burst counter and read response capture
  always_comb begin
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    r0_rvalid_d = 1'b0;
    r1_rvalid_d = 1'b0;
    r0_rdata_d  = r0_rdata_q;
    r1_rdata_d  = r1_rdata_q;

    if (gnt_any) begin
      if (r1_gnt == owner_q) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
      end else begin
        owner_d = r1_gnt;
        cnt_d   = CW'(1);
      end
    end else begin
      cnt_d = '0;
    end

    if (r0_gnt && !r0_we) begin
      r0_rvalid_d = 1'b1;
      r0_rdata_d  = mem_readdata;
    end
    if (r1_gnt && !r1_we) begin
      r1_rvalid_d = 1'b1;
      r1_rdata_d  = mem_readdata;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      r0_rvalid_q <= 1'b0;
      r1_rvalid_q <= 1'b0;
      r0_rdata_q  <= '0;
      r1_rdata_q  <= '0;
    end else begin
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      r0_rvalid_q <= r0_rvalid_d;
      r1_rvalid_q <= r1_rvalid_d;
      r0_rdata_q  <= r0_rdata_d;
      r1_rdata_q  <= r1_rdata_d;
    end
  end

  assign owner     = owner_q;
  assign r0_rvalid = r0_rvalid_q;
  assign r1_rvalid = r1_rvalid_q;
  assign r0_rdata  = r0_rdata_q;
  assign r1_rdata  = r1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model.
module tb_dmem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          r0_req, r1_req, r0_we, r1_we;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_writedata, mem_readdata;
  logic          mem_memread, mem_memwrite;
  logic          owner;

  int tests;
  int fails;

  logic [DW-1:0] mem [64];

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .r0_req       (r0_req),
    .r0_we        (r0_we),
    .r0_addr      (r0_addr),
    .r0_wdata     (r0_wdata),
    .r1_req       (r1_req),
    .r1_we        (r1_we),
    .r1_addr      (r1_addr),
    .r1_wdata     (r1_wdata),
    .r0_gnt       (r0_gnt),
    .r1_gnt       (r1_gnt),
    .r0_rvalid    (r0_rvalid),
    .r1_rvalid    (r1_rvalid),
    .r0_rdata     (r0_rdata),
    .r1_rdata     (r1_rdata),
    .mem_address  (mem_address),
    .mem_writedata(mem_writedata),
    .mem_memread  (mem_memread),
    .mem_memwrite (mem_memwrite),
    .mem_readdata (mem_readdata),
    .owner        (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge
  assign mem_readdata = mem[mem_address[7:2]];
  always @(posedge clk) begin
    if (mem_memwrite) mem[mem_address[7:2]] <= mem_writedata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    r0_req = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0;
  endtask

  initial begin
    logic [11:0] seq_a;
    logic [4:0]  seq_b;
    tests = 0;
    fails = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'(i);

    // Reset state, including a request held while in reset
    rst = 1'b0;
    idle_inputs();
    r0_req = 1'b1;
    #2;
    chk("rst_r0_gnt", 32'(r0_gnt), 32'd0);
    chk("rst_memread", 32'(mem_memread), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_r0_rvalid", 32'(r0_rvalid), 32'd0);
    chk("rst_r0_rdata", r0_rdata, 32'd0);
    r0_req = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();

    // Single read by port 0
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h8;
    #1;
    chk("rd_r0_gnt", 32'(r0_gnt), 32'd1);
    chk("rd_r1_gnt", 32'(r1_gnt), 32'd0);
    chk("rd_memread", 32'(mem_memread), 32'd1);
    chk("rd_memwrite", 32'(mem_memwrite), 32'd0);
    chk("rd_addr", mem_address, 32'h8);
    cyc();
    chk("rd_rvalid", 32'(r0_rvalid), 32'd1);
    chk("rd_rdata", r0_rdata, 32'd2);
    idle_inputs();
    #1;
    chk("idle_addr", mem_address, 32'd0);
    chk("idle_gnt", 32'(r0_gnt | r1_gnt), 32'd0);
    cyc();
    chk("rd_rvalid_pulse", 32'(r0_rvalid), 32'd0);
    chk("rd_rdata_hold", r0_rdata, 32'd2);

    // Port 1 write, then port 0 reads it back
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'h10; r1_wdata = 32'hDEADBEEF;
    #1;
    chk("wr_r1_gnt", 32'(r1_gnt), 32'd1);
    chk("wr_memwrite", 32'(mem_memwrite), 32'd1);
    chk("wr_memread", 32'(mem_memread), 32'd0);
    chk("wr_addr", mem_address, 32'h10);
    chk("wr_wdata", mem_writedata, 32'hDEADBEEF);
    cyc();
    chk("wr_no_rvalid", 32'(r1_rvalid), 32'd0);
    chk("wr_owner", 32'(owner), 32'd1);
    idle_inputs();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h10;
    #1;
    chk("rb_r0_gnt", 32'(r0_gnt), 32'd1);
    cyc();
    chk("rb_rvalid", 32'(r0_rvalid), 32'd1);
    chk("rb_rdata", r0_rdata, 32'hDEADBEEF);
    chk("rb_r1_rvalid", 32'(r1_rvalid), 32'd0);
    chk("rb_owner", 32'(owner), 32'd0);
    idle_inputs();

    // Continuous contention from reset: r0 x4, r1 x4, r0 x4 (bit set = r1 wins)
    rst = 1'b0;
    #1;
    chk("rst2_owner", 32'(owner), 32'd0);
    rst = 1'b1;
    seq_a = 12'b0000_1111_0000;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h4;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'hC;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk($sformatf("cont_r0_gnt_%0d", k), 32'(r0_gnt), 32'(!seq_a[k]));
      chk($sformatf("cont_r1_gnt_%0d", k), 32'(r1_gnt), 32'(seq_a[k]));
      chk($sformatf("cont_onehot_%0d", k), 32'(r0_gnt & r1_gnt), 32'd0);
      cyc();
      chk($sformatf("cont_owner_%0d", k), 32'(owner), 32'(seq_a[k]));
    end
    idle_inputs();
    #1;
    chk("cont_r0_rdata", r0_rdata, 32'd1);
    chk("cont_r1_rdata", r1_rdata, 32'd3);

    // Owner r0 at cnt 2, one idle cycle clears cnt, then r0 x4 before r1
    rst = 1'b0;
    #1;
    rst = 1'b1;
    cyc();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h4;
    cyc();
    cyc();
    r0_req = 1'b0;
    cyc();
    chk("drop_owner", 32'(owner), 32'd0);
    r0_req = 1'b1;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'hC;
    seq_b = 5'b10000;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("drop_r0_gnt_%0d", k), 32'(r0_gnt), 32'(!seq_b[k]));
      chk($sformatf("drop_r1_gnt_%0d", k), 32'(r1_gnt), 32'(seq_b[k]));
      cyc();
    end
    idle_inputs();

    // Reset between a granted read and its response
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'h14;
    #1;
    chk("mid_r1_gnt", 32'(r1_gnt), 32'd1);
    cyc();
    chk("mid_pre_rvalid", 32'(r1_rvalid), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_rvalid", 32'(r1_rvalid), 32'd0);
    chk("mid_rdata", r1_rdata, 32'd0);
    chk("mid_owner", 32'(owner), 32'd0);
    chk("mid_gnt", 32'(r1_gnt), 32'd0);
    chk("mid_memread", 32'(mem_memread), 32'd0);
    chk("mid_addr", mem_address, 32'd0);
    cyc();
    chk("mid_hold_rvalid", 32'(r1_rvalid), 32'd0);
    idle_inputs();
    rst = 1'b1;
    cyc();

    // Idle after a read: strobes low, rdata retained
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h18;
    cyc();
    idle_inputs();
    cyc();
    cyc();
    chk("idle_memread", 32'(mem_memread), 32'd0);
    chk("idle_memwrite", 32'(mem_memwrite), 32'd0);
    chk("idle_addr2", mem_address, 32'd0);
    chk("idle_rvalid", 32'(r0_rvalid), 32'd0);
    chk("idle_rdata", r0_rdata, 32'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
